// File: rtl/psum_read_arbiter.sv
// Round-robin arbiter that shares one psum_reader among REQ_COUNT requesters,
// sequencing issue / ack / done with an ack timeout and per-requester status pulses.

module psum_req_lane #(
    parameter int ADDR_WIDTH = 8,
    parameter int GPR_WIDTH  = 6
) (
    input  logic [GPR_WIDTH-1:0]  op_slice,
    input  logic [ADDR_WIDTH-1:0] len_slice,
    output logic [GPR_WIDTH-1:0]  op_id,
    output logic [ADDR_WIDTH-1:0] seq_length,
    output logic                  len_zero
);
    assign op_id      = op_slice;
    assign seq_length = len_slice;
    assign len_zero   = (len_slice == '0);
endmodule

module psum_read_arbiter #(
    parameter int REQ_COUNT   = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int GPR_WIDTH   = 6,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [REQ_COUNT-1:0]            req_valid,
    input  logic [REQ_COUNT*GPR_WIDTH-1:0]  req_op_id_flat,
    input  logic [REQ_COUNT*ADDR_WIDTH-1:0] req_seq_length_flat,
    output logic [REQ_COUNT-1:0]            req_grant,
    output logic [REQ_COUNT-1:0]            req_done,
    output logic [REQ_COUNT-1:0]            req_error,
    output logic                            start_read,
    output logic [GPR_WIDTH-1:0]            read_operation_id,
    output logic [ADDR_WIDTH-1:0]           read_seq_length,
    input  logic                            reader_busy,
    input  logic                            reader_no_match,
    input  logic                            reader_req_accepted,
    output logic                            arb_busy,
    output logic [$clog2(REQ_COUNT)-1:0]    grant_index
);
    localparam int IDX_W = $clog2(REQ_COUNT);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    typedef struct packed {
        logic [GPR_WIDTH-1:0]  op_id;
        logic [ADDR_WIDTH-1:0] seq_length;
        logic [IDX_W-1:0]      idx;
    } req_t;

    state_t           state;
    req_t             cur;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] ack_cnt;

    logic [REQ_COUNT-1:0][GPR_WIDTH-1:0]  lane_op;
    logic [REQ_COUNT-1:0][ADDR_WIDTH-1:0] lane_len;
    logic [REQ_COUNT-1:0]                 lane_zero;

    generate
        for (genvar g = 0; g < REQ_COUNT; g++) begin : g_lane
            psum_req_lane #(
                .ADDR_WIDTH(ADDR_WIDTH),
                .GPR_WIDTH (GPR_WIDTH)
            ) u_lane (
                .op_slice  (req_op_id_flat[g*GPR_WIDTH +: GPR_WIDTH]),
                .len_slice (req_seq_length_flat[g*ADDR_WIDTH +: ADDR_WIDTH]),
                .op_id     (lane_op[g]),
                .seq_length(lane_len[g]),
                .len_zero  (lane_zero[g])
            );
        end
    endgenerate

    // Search starts one past the last-served requester so service rotates.
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [REQ_COUNT-1:0] sel_onehot;
    logic [REQ_COUNT-1:0] cur_onehot;

    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= REQ_COUNT; i++) begin
            cand = (int'(rr_ptr) + i) % REQ_COUNT;
            if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
        sel_onehot = REQ_COUNT'(1) << sel_idx;
        cur_onehot = REQ_COUNT'(1) << cur.idx;
    end

    assign read_operation_id = cur.op_id;
    assign read_seq_length   = cur.seq_length;
    assign grant_index       = cur.idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= IDX_W'(REQ_COUNT - 1);
            cur        <= '0;
            ack_cnt    <= '0;
            req_grant  <= '0;
            req_done   <= '0;
            req_error  <= '0;
            start_read <= 1'b0;
            arb_busy   <= 1'b0;
        end else begin
            req_grant  <= '0;
            req_done   <= '0;
            req_error  <= '0;
            start_read <= 1'b0;
            case (state)
                IDLE: begin
                    // Holding off while the reader is busy keeps start_read off a busy reader.
                    if (sel_found && !reader_busy) begin
                        cur <= '{op_id: lane_op[sel_idx], seq_length: lane_len[sel_idx], idx: sel_idx};
                        rr_ptr    <= sel_idx;
                        req_grant <= sel_onehot;
                        if (lane_zero[sel_idx]) begin
                            req_error <= sel_onehot;
                        end else begin
                            state      <= ISSUE;
                            start_read <= 1'b1;
                            arb_busy   <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT_ACK;
                    ack_cnt <= '0;
                end
                WAIT_ACK: begin
                    if (reader_req_accepted) begin
                        state <= WAIT_DONE;
                    end else if (reader_no_match || ack_cnt == CNT_LAST) begin
                        req_error <= cur_onehot;
                        state     <= IDLE;
                        arb_busy  <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!reader_busy) begin
                        req_done <= cur_onehot;
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
